// File: rtl/axi_loader_scheduler.sv
// Run sequencer for a bank of AXI traffic-generator loaders: fills each loader's
// descriptor FIFO round-robin, releases them together, and times the run.
`timescale 1ns/1ps
module axi_loader_scheduler #(
  parameter int          NUM_LOADERS  = 4,
  parameter int          MAX_ID_WIDTH = 5,
  parameter int          FIFO_DEPTH   = 64,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic                    run_i,
  input  logic [15:0]             cfg_txn_count_i,
  input  logic [7:0]              cfg_axlen_i,
  input  logic [1:0]              cfg_write_mode_i,
  input  logic                    cfg_resp_wait_i,
  input  logic [MAX_ID_WIDTH-1:0] cfg_id_base_i,
  output logic [NUM_LOADERS-1:0]  push_o,
  output logic                    write_o,
  output logic [7:0]              axlen_o,
  output logic [MAX_ID_WIDTH-1:0] id_o,
  output logic                    resp_wait_o,
  output logic                    start_o,
  input  logic [NUM_LOADERS-1:0]  idle_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [31:0]             cycles_o
);

  localparam int              LD_W      = (NUM_LOADERS > 1) ? $clog2(NUM_LOADERS) : 1;
  localparam logic [LD_W-1:0] LD_LAST   = LD_W'(NUM_LOADERS - 1);
  localparam logic [15:0]     DEPTH_CAP = 16'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_GUARD, S_RUN, S_DONE} state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  state_e                  state_q, state_d;
  logic [15:0]             count_q, count_d;
  logic [15:0]             txn_q, txn_d;
  logic [LD_W-1:0]         ld_q, ld_d;
  logic [7:0]              axlen_cfg_q, axlen_cfg_d;
  logic [1:0]              mode_q, mode_d;
  logic                    resp_cfg_q, resp_cfg_d;
  logic [MAX_ID_WIDTH-1:0] id_base_q, id_base_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [31:0]             cnt_q, cnt_d;

  logic [NUM_LOADERS-1:0]  push_q, push_d;
  logic                    write_q, write_d;
  logic [7:0]              axlen_q, axlen_d;
  logic [MAX_ID_WIDTH-1:0] id_q, id_d;
  logic                    resp_q, resp_d;
  logic                    start_q, start_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [31:0]             cycles_q, cycles_d;
  logic                    emit;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    txn_d       = txn_q;
    ld_d        = ld_q;
    axlen_cfg_d = axlen_cfg_q;
    mode_d      = mode_q;
    resp_cfg_d  = resp_cfg_q;
    id_base_d   = id_base_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    push_d      = '0;
    write_d     = write_q;
    axlen_d     = axlen_q;
    id_d        = id_q;
    resp_d      = resp_q;
    start_d     = start_q;
    done_d      = 1'b0;
    cycles_d    = cycles_q;
    emit        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run_i) begin
          axlen_cfg_d = cfg_axlen_i;
          mode_d      = cfg_write_mode_i;
          resp_cfg_d  = cfg_resp_wait_i;
          id_base_d   = cfg_id_base_i;
          count_d     = (cfg_txn_count_i > DEPTH_CAP) ? DEPTH_CAP : cfg_txn_count_i;
          txn_d       = '0;
          ld_d        = '0;
          cnt_d       = '0;
          if (count_d == 16'd0) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            cycles_d = '0;
          end else begin
            state_d = S_FILL;
            emit    = 1'b1;
          end
        end
      end
      S_FILL: begin
        // Outputs are registered, so each FILL cycle prepares the next descriptor.
        if (mode_q == 2'd3) lfsr_d = lfsr_step(lfsr_q);
        if (ld_q == LD_LAST && txn_q == count_q - 16'd1) begin
          state_d = S_GUARD;
          start_d = 1'b1;
        end else begin
          if (ld_q == LD_LAST) begin
            ld_d  = '0;
            txn_d = txn_q + 16'd1;
          end else begin
            ld_d = ld_q + LD_W'(1);
          end
          emit = 1'b1;
        end
      end
      S_GUARD: begin
        // Loaders still report idle for one cycle after start; do not sample them yet.
        cnt_d   = sat_inc(cnt_q);
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = sat_inc(cnt_q);
        if (&idle_i) begin
          state_d  = S_DONE;
          start_d  = 1'b0;
          done_d   = 1'b1;
          cycles_d = cnt_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (emit) begin
      push_d  = NUM_LOADERS'(1) << ld_d;
      id_d    = id_base_d + MAX_ID_WIDTH'(txn_d);
      axlen_d = axlen_cfg_d;
      resp_d  = resp_cfg_d;
      case (mode_d)
        2'd0:    write_d = 1'b0;
        2'd1:    write_d = 1'b1;
        2'd2:    write_d = txn_d[0];
        default: write_d = lfsr_d[0];
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_SEED;
      push_q   <= '0;
      write_q  <= 1'b0;
      axlen_q  <= '0;
      id_q     <= '0;
      resp_q   <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      push_q   <= push_d;
      write_q  <= write_d;
      axlen_q  <= axlen_d;
      id_q     <= id_d;
      resp_q   <= resp_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cycles_q <= cycles_d;
    end
  end

  // Run-scoped working registers; always initialised on run acceptance.
  always_ff @(posedge clk_i) begin
    count_q     <= count_d;
    txn_q       <= txn_d;
    ld_q        <= ld_d;
    axlen_cfg_q <= axlen_cfg_d;
    mode_q      <= mode_d;
    resp_cfg_q  <= resp_cfg_d;
    id_base_q   <= id_base_d;
    cnt_q       <= cnt_d;
  end

  assign push_o      = push_q;
  assign write_o     = write_q;
  assign axlen_o     = axlen_q;
  assign id_o        = id_q;
  assign resp_wait_o = resp_q;
  assign start_o     = start_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign cycles_o    = cycles_q;

endmodule

// File: doc/axi_loader_scheduler.md
# axi_loader_scheduler

Sequencer for a bank of `NUM_LOADERS` AXI traffic-generator loaders. Each loader exposes a descriptor push port, a `start` level input and an `idle` status output. On a `run_i` pulse the block:
- fills every loader's descriptor FIFOs round-robin from a latched configuration,
- releases all loaders simultaneously,
- waits until every loader reports idle,
- reports total elapsed run cycles.

It sits between the testbench/cosim control registers and the loader array of the NoC traffic harness.

## Interface
Parameters:
- `NUM_LOADERS`, 4: number of loaders driven (1..16).
- `MAX_ID_WIDTH`, 5: width of the descriptor ID field.
- `FIFO_DEPTH`, 64: depth of each loader descriptor FIFO; the transaction count is clamped to this.
- `LFSR_SEED`, 16'hACE1: nonzero reset seed of the write/read selection LFSR.

Ports:
- `clk_i`  in  1  clock.
- `arstn_i`  in  1  reset, asynchronous, active-low.
- `run_i`  in  1  start pulse; accepted only in IDLE.
- `cfg_txn_count_i`  in  16  descriptors per loader.
- `cfg_axlen_i`  in  8  AxLEN for every descriptor.
- `cfg_write_mode_i`  in  2  0 all reads, 1 all writes, 2 alternating, 3 LFSR.
- `cfg_resp_wait_i`  in  1  resp_wait flag for every descriptor.
- `cfg_id_base_i`  in  MAX_ID_WIDTH  first transaction ID.
- `push_o`  out  NUM_LOADERS  one-hot descriptor push strobe.
- `write_o`  out  1  descriptor direction, 1 = write.
- `axlen_o`  out  8  descriptor length.
- `id_o`  out  MAX_ID_WIDTH  descriptor ID.
- `resp_wait_o`  out  1  descriptor resp_wait.
- `start_o`  out  1  common start level to all loaders.
- `idle_i`  in  NUM_LOADERS  per-loader idle status.
- `busy_o`  out  1  high in any state other than IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `cycles_o`  out  32  run duration of the last completed run.

## Operation
- **States:** IDLE, FILL, GUARD, RUN, DONE.
- **IDLE → FILL:** on `run_i`. In the same cycle latch all `cfg_*` inputs:
  - `count = min(cfg_txn_count_i, FIFO_DEPTH)`.
  - Clear `txn_idx`, `ld_idx` and the cycle counter.
  - If `count == 0`, go straight to DONE.
- **`run_i` when not in IDLE:** ignored.
- **FILL:** one descriptor per cycle, no backpressure (loader FIFO `ready` is not used).
  - `push_o = 1 << ld_idx`.
  - `id_o = cfg_id_base + txn_idx`, truncated mod 2^`MAX_ID_WIDTH`.
  - `axlen_o` and `resp_wait_o` come from the latched configuration.
  - `write_o` by mode:
    - mode 0: 0.
    - mode 1: 1.
    - mode 2: `txn_idx[0]`.
    - mode 3: `lfsr[0]`.
- **Index advance in FILL:**
  - `ld_idx` increments each cycle.
  - On wrap from `NUM_LOADERS-1` to 0, `txn_idx` increments.
  - After the push with `txn_idx == count-1` and `ld_idx == NUM_LOADERS-1`, go to GUARD.
- **Fill bound:** total pushes per loader never exceed `count`, so neither loader FIFO can overflow.
- **LFSR:** 16-bit Fibonacci, taps 16/14/13/11. Reset to `LFSR_SEED`. Advances only on FILL cycles in mode 3. Not reseeded per run.
- **GUARD:** `start_o = 1` for exactly one cycle and `idle_i` is ignored, because loaders deassert idle one cycle after seeing start. Then go to RUN.
- **RUN:** `start_o = 1`. When `&idle_i == 1`, go to DONE.
- **DONE:** `start_o = 0`, `done_o = 1` for one cycle, `cycles_o` updated. Then go to IDLE.
- **Cycle counter:**
  - Counts cycles spent in GUARD and RUN.
  - Saturates at 2^32-1.
  - Copied to `cycles_o` on entry to DONE; held until the next DONE.

## Timing
- **Reset values:** state IDLE; `push_o = 0`; `write_o = 0`; `axlen_o = 0`; `id_o = 0`; `resp_wait_o = 0`; `start_o = 0`; `busy_o = 0`; `done_o = 0`; `cycles_o = 0`; LFSR = seed.
- All outputs are registered.
- **Run sequence** (`run_i` sampled at edge t):
  - First push visible at cycle t+1.
  - Last push at cycle t + `NUM_LOADERS`·`count`.
  - `start_o` rises the cycle after the last push.
  - `done_o` is asserted the cycle after `&idle_i` is sampled high in RUN.
- **Zero count:** `done_o` at t+1, `cycles_o = 0`, `start_o` never asserted.
- **Descriptor fields** are valid only while `push_o != 0`; otherwise they hold their last values.
- **Reset mid-run:** everything returns to reset values immediately. Loaders share `arstn_i`, so their FIFOs are cleared coherently.
- **Loader that never goes idle:** the block stays in RUN indefinitely (no timeout).

## Test plan
- `NUM_LOADERS=4`, count=3, mode 1, axlen=7, id_base=2 → 12 consecutive pushes:
  - `push_o` = 1,2,4,8 repeating.
  - `id_o` = 2,2,2,2,3,3,3,3,4,4,4,4.
  - All `write_o = 1`, `axlen_o = 7`.
  - `start_o` rises at t+13.
- Mode 2, count=4 → `write_o` per round = 0,1,0,1. Mode 0 → all `write_o = 0`.
- count=100 with `FIFO_DEPTH=64` → exactly 64 pushes per loader (256 total).
- Idle model deasserting `idle_i` at GUARD+1 and reasserting all lanes 50 cycles later:
  - `done_o` is a single pulse.
  - `cycles_o = 51`.
  - `run_i` pulses while busy are ignored.
- count=0 → `done_o` at t+1, no pushes, `cycles_o = 0`.
- `arstn_i` asserted mid-FILL → all outputs return to reset values the same cycle; a fresh run then behaves identically to the first.
